// File: rtl/mem_arbiter_pkg.sv
// Shared types for the RAM port arbiter: RAM handshake states, arbiter states, RAM request payload.
package mem_arbiter_pkg;

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned WDOG_W   = 10;
   localparam int unsigned STARVE_W = 4;

   typedef enum logic [1:0] {
      RS_FREE   = 2'd0,
      RS_BUSY   = 2'd1,
      RS_ACCESS = 2'd2,
      RS_ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic              ren;
      logic              wen;
      logic [WORD_W-1:0] addr;
      logic [WORD_W-1:0] store;
   } ram_req_t;

endpackage

// File: rtl/mem_timeout.sv
// Watchdog counter for a granted RAM transaction; expired marks the last cycle allowed.
module mem_timeout
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [WDOG_W-1:0] wdog;

   // Count grant cycles without a RAM response; cleared back to zero before each grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog <= '0;
      end else if (clr) begin
         wdog <= '0;
      end else if (en) begin
         wdog <= wdog + WDOG_W'(1);
      end
   end

   // Expiry is the final permitted wait cycle, so it acts as an error completion in that cycle.
   always_comb begin
      expired = (wdog == WDOG_W'(TIMEOUT - 1));
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single RAM port arbiter between instruction fetch and data path, data priority with
// bounded instruction starvation and a watchdog on hung transactions.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT      = 255
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   output logic [WORD_W-1:0] iload,
   output logic              iwait,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic [WORD_W-1:0] dload,
   output logic              dwait,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              err
);

   arb_state_t          state;
   logic [STARVE_W-1:0] starve_cnt;
   ram_req_t            ram_req;
   ramstate_t           rs;
   logic                d_req;
   logic                i_act;
   logic                d_act;
   logic                ram_ok;
   logic                ram_err;
   logic                wd_expired;
   logic                wd_en;
   logic                done;
   logic                fault_done;
   logic                starved;

   // Decode the request/RAM status and decide whether the live grant completes this cycle.
   always_comb begin
      rs         = ramstate_t'(ramstate);
      d_req      = dREN | dWEN;
      i_act      = (state == IGNT) & iREN;
      d_act      = (state == DGNT) & d_req;
      ram_ok     = (rs == RS_ACCESS);
      ram_err    = (rs == RS_ERROR);
      wd_en      = (i_act | d_act) & ~ram_ok & ~ram_err;
      done       = (i_act | d_act) & (ram_ok | ram_err | wd_expired);
      fault_done = (i_act | d_act) & ~ram_ok & (ram_err | wd_expired);
      starved    = iREN & (starve_cnt == STARVE_W'(STARVE_LIMIT));
   end

   mem_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (CLK),
      .rst     (RST),
      .clr     (state == IDLE),
      .en      (wd_en),
      .expired (wd_expired)
   );

   // Arbiter FSM, starvation counter and sticky fault flag.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         starve_cnt <= '0;
         err        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (d_req && !starved) begin
                  state <= DGNT;
               end else if (iREN) begin
                  state <= IGNT;
               end
            end
            IGNT: begin
               if (!iREN || done) begin
                  state <= IDLE;
               end
            end
            DGNT: begin
               if (!d_req || done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (fault_done || (dREN && dWEN)) begin
            err <= 1'b1;
         end

         if (!iREN) begin
            starve_cnt <= '0;
         end else if ((state == IDLE) && !(d_req && !starved)) begin
            starve_cnt <= '0;
         end else if (d_act && done && (starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
         end
      end
   end

   // RAM request follows the granted requester live; a withdrawn request drops the enables at once.
   always_comb begin
      ram_req = '0;
      case (state)
         IGNT: begin
            if (iREN) begin
               ram_req.ren  = 1'b1;
               ram_req.addr = iaddr;
            end
         end
         DGNT: begin
            if (d_req) begin
               ram_req.addr = daddr;
               if (dWEN) begin
                  ram_req.wen   = 1'b1;
                  ram_req.store = dstore;
               end else begin
                  ram_req.ren = 1'b1;
               end
            end
         end
         default: ram_req = '0;
      endcase
      ramREN   = ram_req.ren;
      ramWEN   = ram_req.wen;
      ramaddr  = ram_req.addr;
      ramstore = ram_req.store;
   end

   // Requester handshake: wait drops only in the completion cycle, load data only on a good read.
   always_comb begin
      iwait = iREN & ~(i_act & done);
      dwait = d_req & ~(d_act & done);
      iload = (i_act && ram_ok) ? ramload : '0;
      dload = (d_act && ram_ok && !dWEN) ? ramload : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle vector table plus starvation, withdraw and reset sequences.
module tb_mem_arbiter;

   localparam int unsigned LIM = 4;
   localparam int unsigned TMO = 8;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        iREN = 1'b0;
   logic [31:0] iaddr = '0;
   logic [31:0] iload;
   logic        iwait;
   logic        dREN = 1'b0;
   logic        dWEN = 1'b0;
   logic [31:0] daddr = '0;
   logic [31:0] dstore = '0;
   logic [31:0] dload;
   logic        dwait;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload = '0;
   logic [1:0]  ramstate = 2'd0;
   logic        err;

   int checks = 0;
   int failures = 0;

   mem_arbiter #(
      .STARVE_LIMIT (LIM),
      .TIMEOUT      (TMO)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iload    (iload),
      .iwait    (iwait),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dload    (dload),
      .dwait    (dwait),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate),
      .err      (err)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit          rst;
      int          n;
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dw;
      logic [31:0] da;
      logic [31:0] ds;
      logic [31:0] rl;
      logic [1:0]  rs;
      logic        e_iw;
      logic        e_dw;
      logic [31:0] e_il;
      logic [31:0] e_dl;
      logic        e_rre;
      logic        e_rwe;
      logic [31:0] e_ra;
      logic [31:0] e_rst;
      logic        e_err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit r, int n, logic ir, logic [31:0] ia, logic dr, logic dw,
                               logic [31:0] da, logic [31:0] ds, logic [31:0] rl, logic [1:0] rs,
                               logic e_iw, logic e_dw, logic [31:0] e_il, logic [31:0] e_dl,
                               logic e_rre, logic e_rwe, logic [31:0] e_ra, logic [31:0] e_rst,
                               logic e_err);
      vec_t v;
      v.rst = r;  v.n = n;  v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw;
      v.da = da;  v.ds = ds; v.rl = rl; v.rs = rs;
      v.e_iw = e_iw; v.e_dw = e_dw; v.e_il = e_il; v.e_dl = e_dl;
      v.e_rre = e_rre; v.e_rwe = e_rwe; v.e_ra = e_ra; v.e_rst = e_rst; v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      step();
      RST = 1'b0;
   endtask

   task automatic idle_inputs();
      iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
      daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;
   endtask

   localparam logic [1:0] FR = 2'd0, BS = 2'd1, AC = 2'd2, ER = 2'd3;

   int dcnt;
   int icnt;
   int d_before;
   int d_between;

   initial begin
      // ---- reset state with requests pending ----
      iREN = 1'b1; dREN = 1'b1; iaddr = 32'h100; daddr = 32'h200; ramload = 32'hFFFF_FFFF;
      ramstate = AC;
      #2;
      chk("reset_outputs", {ramREN, ramWEN, ramaddr, ramstore, iload, dload, err},
          {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0});
      chk("reset_waits", {iwait, dwait}, {1'b1, 1'b1});
      step();
      idle_inputs();
      RST = 1'b0;

      // ---- vector table ----
      // single write, BUSY x2 then ACCESS, then IDLE turnaround and a withdrawn regrant
      tbl.push_back(mk(0,1, 0,0, 0,1,32'h40,32'hDEADBEEF, 0,FR, 0,1,0,0, 0,0,0,0, 0));
      tbl.push_back(mk(0,2, 0,0, 0,1,32'h40,32'hDEADBEEF, 0,BS, 0,1,0,0, 0,1,32'h40,32'hDEADBEEF, 0));
      tbl.push_back(mk(0,1, 0,0, 0,1,32'h40,32'hDEADBEEF, 0,AC, 0,0,0,0, 0,1,32'h40,32'hDEADBEEF, 0));
      tbl.push_back(mk(0,1, 0,0, 0,1,32'h40,32'hDEADBEEF, 0,FR, 0,1,0,0, 0,0,0,0, 0));
      tbl.push_back(mk(0,1, 0,0, 0,0,0,0, 0,FR, 0,0,0,0, 0,0,0,0, 0));
      tbl.push_back(mk(0,1, 0,0, 0,0,0,0, 0,FR, 0,0,0,0, 0,0,0,0, 0));
      // simultaneous instruction and data read: data first, turnaround, then instruction
      tbl.push_back(mk(0,1, 1,32'h100, 1,0,32'h200,0, 0,FR, 1,1,0,0, 0,0,0,0, 0));
      tbl.push_back(mk(0,1, 1,32'h100, 1,0,32'h200,0, 32'hAAAAAAAA,BS, 1,1,0,0, 1,0,32'h200,0, 0));
      tbl.push_back(mk(0,1, 1,32'h100, 1,0,32'h200,0, 32'h11111111,AC, 1,0,0,32'h11111111, 1,0,32'h200,0, 0));
      tbl.push_back(mk(0,1, 1,32'h100, 0,0,0,0, 0,FR, 1,0,0,0, 0,0,0,0, 0));
      tbl.push_back(mk(0,1, 1,32'h100, 0,0,0,0, 32'h55555555,BS, 1,0,0,0, 1,0,32'h100,0, 0));
      tbl.push_back(mk(0,1, 1,32'h100, 0,0,0,0, 32'h2402000A,AC, 0,0,32'h2402000A,0, 1,0,32'h100,0, 0));
      tbl.push_back(mk(0,1, 0,0, 0,0,0,0, 0,FR, 0,0,0,0, 0,0,0,0, 0));
      // watchdog: BUSY forever, 8th grant cycle completes as an error
      tbl.push_back(mk(0,1, 0,0, 1,0,32'h300,0, 0,FR, 0,1,0,0, 0,0,0,0, 0));
      tbl.push_back(mk(0,7, 0,0, 1,0,32'h300,0, 32'h12345678,BS, 0,1,0,0, 1,0,32'h300,0, 0));
      tbl.push_back(mk(0,1, 0,0, 1,0,32'h300,0, 32'h12345678,BS, 0,0,0,0, 1,0,32'h300,0, 0));
      tbl.push_back(mk(0,1, 0,0, 0,0,0,0, 0,FR, 0,0,0,0, 0,0,0,0, 1));
      // dREN&dWEN after a fresh reset: write issued, err next edge, ERROR completion
      tbl.push_back(mk(1,1, 0,0, 1,1,32'h8,32'h55, 0,FR, 0,1,0,0, 0,0,0,0, 0));
      tbl.push_back(mk(0,1, 0,0, 1,1,32'h8,32'h55, 0,BS, 0,1,0,0, 0,1,32'h8,32'h55, 1));
      tbl.push_back(mk(0,1, 0,0, 1,1,32'h8,32'h55, 32'hFFFFFFFF,ER, 0,0,0,0, 0,1,32'h8,32'h55, 1));
      tbl.push_back(mk(0,1, 0,0, 0,0,0,0, 0,FR, 0,0,0,0, 0,0,0,0, 1));
      // ERROR on an instruction grant
      tbl.push_back(mk(0,1, 1,32'h104, 0,0,0,0, 0,FR, 1,0,0,0, 0,0,0,0, 1));
      tbl.push_back(mk(0,1, 1,32'h104, 0,0,0,0, 32'hCAFEF00D,ER, 0,0,0,0, 1,0,32'h104,0, 1));
      tbl.push_back(mk(0,1, 0,0, 0,0,0,0, 0,FR, 0,0,0,0, 0,0,0,0, 1));

      foreach (tbl[r]) begin
         if (tbl[r].rst) begin
            idle_inputs();
            do_reset();
         end
         for (int k = 0; k < tbl[r].n; k++) begin
            iREN = tbl[r].ir; iaddr = tbl[r].ia; dREN = tbl[r].dr; dWEN = tbl[r].dw;
            daddr = tbl[r].da; dstore = tbl[r].ds; ramload = tbl[r].rl; ramstate = tbl[r].rs;
            #1;
            chk($sformatf("row%0d.%0d", r, k),
                {iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err},
                {tbl[r].e_iw, tbl[r].e_dw, tbl[r].e_il, tbl[r].e_dl, tbl[r].e_rre,
                 tbl[r].e_rwe, tbl[r].e_ra, tbl[r].e_rst, tbl[r].e_err});
            step();
         end
      end

      // ---- starvation: both requesters held, RAM answers immediately ----
      idle_inputs();
      do_reset();
      iREN = 1'b1; iaddr = 32'h100; dREN = 1'b1; daddr = 32'h200; ramstate = AC;
      dcnt = 0; icnt = 0; d_before = -1; d_between = -1;
      for (int c = 0; c < 30; c++) begin
         #1;
         if (!dwait && ramREN && ramaddr == 32'h200) dcnt++;
         if (!iwait && ramREN && ramaddr == 32'h100) begin
            icnt++;
            if (icnt == 1) d_before = dcnt;
            if (icnt == 2) d_between = dcnt - d_before;
         end
         step();
      end
      chk("starve_igrants", 160'(icnt >= 2), 160'(1));
      chk("starve_first", 160'(d_before), 160'(LIM));
      chk("starve_resume", 160'(d_between), 160'(LIM));

      // ---- instruction withdrawn in the second IGNT cycle ----
      idle_inputs();
      do_reset();
      iREN = 1'b1; iaddr = 32'h100; ramstate = BS;
      step();
      #1;
      chk("wd_ignt", {ramREN, ramaddr}, {1'b1, 32'h100});
      step();
      iREN = 1'b0;
      #1;
      chk("wd_drop", {ramREN, iwait, err}, {1'b0, 1'b0, 1'b0});
      step();
      iREN = 1'b1;
      #1;
      chk("wd_idle", {ramREN, iwait, err}, {1'b0, 1'b1, 1'b0});

      // ---- asynchronous reset mid data grant ----
      iREN = 1'b0;
      dWEN = 1'b1; daddr = 32'h40; dstore = 32'h1;
      step();
      step();
      chk("rst_dgnt", {ramWEN, ramaddr}, {1'b1, 32'h40});
      dREN = 1'b1;
      step();
      chk("rst_err_set", {err, ramWEN}, {1'b1, 1'b1});
      #2;
      RST = 1'b1;
      #1;
      chk("rst_async", {ramWEN, ramREN, ramaddr, ramstore, err, dwait},
          {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1});
      step();
      RST = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
